// File: rtl/store_buffer_pkg.sv
// Store buffer shared types: control states and posted-write entry layout.
package store_buffer_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int SIZE_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_OUT = 2'd1,
    RD_OUT = 2'd2
  } sb_state_e;

  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              uncached;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular posted-write FIFO; pointers wrap modulo DEPTH.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  sb_entry_t                wr_entry,
  input  logic                     pop,
  output sb_entry_t                head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t       mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_entry;
  end

  assign head_entry = mem[head];

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU data port and sram_to_axi.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_uncached,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        d_req,
  output logic        d_wr,
  output logic [1:0]  d_size,
  output logic [3:0]  d_wstrb,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic        d_uncached,
  input  logic        d_addr_ok,
  input  logic        d_data_ok,
  input  logic [31:0] d_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  sb_state_e   state;
  sb_state_e   state_nxt;
  logic        ack_q;
  logic [PW:0] count;
  sb_entry_t   head_entry;
  sb_entry_t   cpu_entry;
  sb_entry_t   d_entry;

  logic rd_out, wr_out, idle;
  logic empty, full;
  logic wr_acc, drain, rd_go;
  logic push, pop;

  assign rd_out = (state == RD_OUT);
  assign wr_out = (state == WR_OUT);
  assign idle   = (state == IDLE);
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);

  // Outputs are forced quiet while reset is held.
  assign wr_acc = !reset && cpu_req && cpu_wr && !full && !rd_out;
  assign drain  = !reset && idle && !empty;
  assign rd_go  = !reset && idle && empty && !ack_q
                  && cpu_req && !cpu_wr;

  assign push = wr_acc;
  assign pop  = drain && d_addr_ok;

  assign cpu_entry = '{
    size:     cpu_size,
    wstrb:    cpu_wstrb,
    addr:     cpu_addr,
    wdata:    cpu_wdata,
    uncached: cpu_uncached
  };

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .wr_entry   (cpu_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count)
  );

  always_comb begin
    d_entry = cpu_entry;
    d_wr    = 1'b0;
    if (drain) begin
      d_entry = head_entry;
      d_wr    = 1'b1;
    end
  end

  assign d_req      = drain || rd_go;
  assign d_size     = d_entry.size;
  assign d_wstrb    = d_entry.wstrb;
  assign d_addr     = d_entry.addr;
  assign d_wdata    = d_entry.wdata;
  assign d_uncached = d_entry.uncached;

  assign cpu_addr_ok = wr_acc || (rd_go && d_addr_ok);
  assign cpu_data_ok = !reset && (ack_q || (rd_out && d_data_ok));
  assign cpu_rdata   = d_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= wr_acc;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pop)                     state_nxt = WR_OUT;
        else if (rd_go && d_addr_ok) state_nxt = RD_OUT;
      end
      WR_OUT, RD_OUT: begin
        if (d_data_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A response with nothing in flight is dropped by the FSM.
  a_data_ok_outstanding: assert property (
    @(posedge clk) disable iff (reset)
    d_data_ok |-> (wr_out || rd_out)
  ) else $error("store_buffer: d_data_ok with nothing outstanding");

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer with a scoreboarded downstream model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0, cpu_uncached = 1'b0;
  logic [1:0]  cpu_size = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        d_req, d_wr, d_uncached;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
    .cpu_wstrb(cpu_wstrb), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_uncached(cpu_uncached),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
    .cpu_rdata(cpu_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_uncached(d_uncached),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata)
  );

  int checks = 0;
  int errors = 0;

  sb_entry_t exp_q[$];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream slave: d_data_ok one cycle after handshake unless held.
  logic        ds_ready = 1'b0;
  logic        data_hold = 1'b0;
  logic        pend = 1'b0;
  logic        pend_wr = 1'b0;
  logic [31:0] rd_q = '0;
  logic [31:0] mem [logic [31:0]];
  int          wr_done = 0;
  sb_entry_t   m_got, m_exp;

  assign d_addr_ok = ds_ready;
  assign d_data_ok = pend && !data_hold;
  assign d_rdata   = rd_q;

  always @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (d_data_ok) begin
        pend <= 1'b0;
        if (pend_wr) wr_done <= wr_done + 1;
      end
      if (d_req && d_addr_ok) begin
        pend    <= 1'b1;
        pend_wr <= d_wr;
        if (d_wr) begin
          mem[d_addr] = d_wdata;
          m_got = '{size: d_size, wstrb: d_wstrb, addr: d_addr,
                    wdata: d_wdata, uncached: d_uncached};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL drain_order: got unexpected write %0h required none",
                     d_addr);
          end else begin
            m_exp = exp_q.pop_front();
            chk("drain_order", m_got, m_exp);
          end
        end else begin
          rd_q <= mem.exists(d_addr) ? mem[d_addr] : 32'h0;
        end
      end
    end
  end

  task automatic drive_wr(input sb_entry_t e);
    cpu_req      = 1'b1;
    cpu_wr       = 1'b1;
    cpu_size     = e.size;
    cpu_wstrb    = e.wstrb;
    cpu_addr     = e.addr;
    cpu_wdata    = e.wdata;
    cpu_uncached = e.uncached;
  endtask

  // Called just after a negedge; returns at negedge+1 of the accept cycle.
  task automatic issue_write(input sb_entry_t e, output int waited);
    waited = 0;
    drive_wr(e);
    #1;
    while (!cpu_addr_ok && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("wr_accept", cpu_addr_ok, 1'b1);
    if (cpu_addr_ok) exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    cpu_req   = 1'b0;
    ds_ready  = 1'b1;
    data_hold = 1'b0;
    #1;
    while ((dut.u_fifo.count != 0 || pend || dut.state != IDLE) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", (n < 100), 1'b1);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        unc;
  } vec_t;

  vec_t vecs [9];

  function automatic sb_entry_t to_e(input vec_t v);
    return '{size: v.size, wstrb: v.wstrb, addr: v.addr,
             wdata: v.wdata, uncached: v.unc};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, base, n;
    logic [1:0] h0, t0;
    sb_entry_t e;

    vecs[0] = '{2'd2, 4'hF, 32'h0000_4000, 32'h1234_5678, 1'b0};
    vecs[1] = '{2'd0, 4'h4, 32'h0000_4006, 32'h00AB_0000, 1'b1};
    vecs[2] = '{2'd1, 4'hC, 32'h8000_0102, 32'hBEEF_0000, 1'b1};
    vecs[3] = '{2'd2, 4'hF, 32'h0000_4010, 32'hA5A5_5A5A, 1'b0};
    vecs[4] = '{2'd0, 4'h1, 32'h0000_4011, 32'h0000_00C3, 1'b0};
    vecs[5] = '{2'd1, 4'h3, 32'h0000_4020, 32'h0000_7E7E, 1'b1};
    vecs[6] = '{2'd2, 4'hF, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{2'd2, 4'hF, 32'h0000_0000, 32'h0000_0001, 1'b1};
    vecs[8] = '{2'd0, 4'h8, 32'h0000_4033, 32'h9900_0000, 1'b0};

    // Reset: outputs quiet even with a read presented and slave ready.
    ds_ready = 1'b1;
    cpu_req  = 1'b1;
    cpu_wr   = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_addr_ok", cpu_addr_ok, 1'b0);
    chk("rst_data_ok", cpu_data_ok, 1'b0);
    chk("rst_d_req", d_req, 1'b0);
    cpu_req = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_count", dut.u_fifo.count, 0);
    chk("rst_idle_d_req", d_req, 1'b0);

    // Table: field mapping onto the drain request.
    for (int i = 0; i < 3; i++) begin
      ds_ready = 1'b0;
      @(negedge clk);
      issue_write(to_e(vecs[i]), w);
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      chk("tbl_data_ok", cpu_data_ok, 1'b1);
      chk("tbl_d_req", d_req, 1'b1);
      chk("tbl_d_wr", d_wr, 1'b1);
      chk("tbl_d_size", d_size, vecs[i].size);
      chk("tbl_d_wstrb", d_wstrb, vecs[i].wstrb);
      chk("tbl_d_addr", d_addr, vecs[i].addr);
      chk("tbl_d_wdata", d_wdata, vecs[i].wdata);
      chk("tbl_d_unc", d_uncached, vecs[i].unc);
      wait_idle();
    end

    // Posted write with downstream stalled 5 cycles.
    ds_ready = 1'b0;
    @(negedge clk);
    issue_write('{2'd2, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0}, w);
    chk("post_first_try", w, 0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("post_data_ok_t1", cpu_data_ok, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_d_req", d_req, 1'b1);
      chk("stall_d_addr", d_addr, 32'h0000_1000);
      @(negedge clk);
      #1;
      chk("stall_no_ack", cpu_data_ok, 1'b0);
    end
    wait_idle();

    // Fill to DEPTH; fifth write blocked until a pop has registered.
    ds_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = '{2'd2, 4'hF, 32'h0000_3000 + 32'(4 * i), 32'(i + 100), 1'b0};
      drive_wr(e);
      #1;
      chk("fill_accept", cpu_addr_ok, (i < 4));
      if (cpu_addr_ok) exp_q.push_back(e);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("full_block", cpu_addr_ok, 1'b0);
    end
    @(negedge clk);
    ds_ready = 1'b1;
    #1;
    chk("full_pop_cycle", cpu_addr_ok, 1'b0);
    chk("full_drain_req", d_req, 1'b1);
    @(negedge clk);
    #1;
    chk("full_after_pop", cpu_addr_ok, 1'b1);
    if (cpu_addr_ok) exp_q.push_back(e);
    @(negedge clk);
    wait_idle();

    // Read held behind a buffered write, then returns its data.
    ds_ready = 1'b1;
    base = wr_done;
    @(negedge clk);
    issue_write('{2'd2, 4'hF, 32'h0000_2000, 32'h0000_0011, 1'b0}, w);
    @(negedge clk);
    cpu_wr   = 1'b0;
    cpu_addr = 32'h0000_2000;
    #1;
    chk("rd_held", cpu_addr_ok, 1'b0);
    n = 0;
    while (!cpu_addr_ok && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rd_accept", cpu_addr_ok, 1'b1);
    chk("rd_after_wr_done", wr_done, base + 1);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    n = 0;
    while (!cpu_data_ok && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rd_data_ok", cpu_data_ok, 1'b1);
    chk("rd_data", cpu_rdata, 32'h0000_0011);
    wait_idle();

    // Same-cycle push and pop at count 2.
    ds_ready = 1'b0;
    @(negedge clk);
    issue_write('{2'd2, 4'hF, 32'h0000_5000, 32'h0000_0050, 1'b0}, w);
    @(negedge clk);
    issue_write('{2'd2, 4'hF, 32'h0000_5004, 32'h0000_0051, 1'b0}, w);
    @(negedge clk);
    e = '{2'd2, 4'hF, 32'h0000_5008, 32'h0000_0052, 1'b0};
    drive_wr(e);
    ds_ready = 1'b1;
    #1;
    chk("pp_count_before", dut.u_fifo.count, 2);
    chk("pp_accept", cpu_addr_ok, 1'b1);
    chk("pp_drain", d_req, 1'b1);
    if (cpu_addr_ok) exp_q.push_back(e);
    h0 = dut.u_fifo.head;
    t0 = dut.u_fifo.tail;
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("pp_count", dut.u_fifo.count, 2);
    chk("pp_head", dut.u_fifo.head, h0 + 2'd1);
    chk("pp_tail", dut.u_fifo.tail, t0 + 2'd1);
    wait_idle();

    // Wrap sweep: 9 back-to-back writes, order checked by the scoreboard.
    ds_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      issue_write(to_e(vecs[i]), w);
    end
    @(negedge clk);
    wait_idle();

    // Reset mid-operation with three buffered and one in flight.
    ds_ready  = 1'b1;
    data_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue_write('{2'd2, 4'hF, 32'h0000_6000 + 32'(4 * i),
                    32'(i + 200), 1'b0}, w);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("mid_count", dut.u_fifo.count, 3);
    chk("mid_wr_out", (dut.state == WR_OUT), 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    data_hold = 1'b0;
    exp_q.delete();
    #1;
    chk("post_rst_count", dut.u_fifo.count, 0);
    chk("post_rst_d_req", d_req, 1'b0);
    chk("post_rst_data_ok", cpu_data_ok, 1'b0);
    @(negedge clk);
    issue_write('{2'd1, 4'h3, 32'h0000_7000, 32'h0000_CAFE, 1'b1}, w);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("post_rst_ack", cpu_data_ok, 1'b1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
